// File: rtl/hid_key_scheduler.sv
// hid_key_scheduler
// Keystroke scheduler for the USB HID keyboard IN endpoint (EP 0x81).
// Two requesters are arbitrated round-robin into a small FIFO; each queued
// keystroke is played out as an 8-byte press report followed by an 8-byte
// all-zero release report, with an optional idle gap after each report so
// the host's interrupt poll samples both reports.
//
// Ports:
//   clk, usb_rstn           core clock, async active-low reset
//   a_key/a_valid/a_ready   requester A ({modifiers, keycode}), ready = accepted
//   b_key/b_valid/b_ready   requester B, same format
//   ep81_data/valid/ready   byte stream to the USB core EP81
//   fifo_count              registered FIFO occupancy
//   busy                    FSM active or keystrokes pending
module hid_key_scheduler #(
  parameter int FIFO_AW    = 3,
  parameter int GAP_CYCLES = 600000
) (
  input  logic               clk,
  input  logic               usb_rstn,
  input  logic [15:0]        a_key,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [15:0]        b_key,
  input  logic               b_valid,
  output logic               b_ready,
  output logic [7:0]         ep81_data,
  output logic               ep81_valid,
  input  logic               ep81_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               busy
);

  localparam int              DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [23:0]     GAP_C   = 24'(GAP_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRESS   = 3'd1;
  localparam logic [2:0] S_GAP1    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_GAP2    = 3'd4;

  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               last_grant_q;   // 1 = B was granted last
  logic [2:0]         state_q, state_d;
  logic [15:0]        key_q, key_d;
  logic [2:0]         idx_q, idx_d;
  logic [23:0]        gap_q, gap_d;

  logic        full, grant_a, grant_b, push, pop;
  logic [15:0] push_key;

  // Arbiter: a tie goes to whoever did not win last time.
  assign full     = (count_q == DEPTH_C);
  assign grant_a  = ~full & a_valid & (~b_valid | last_grant_q);
  assign grant_b  = ~full & b_valid & (~a_valid | ~last_grant_q);
  assign push     = grant_a | grant_b;
  assign push_key = grant_a ? a_key : b_key;
  assign a_ready  = grant_a;
  assign b_ready  = grant_b;

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_key;
  end

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (push) begin
        wptr_q       <= wptr_q + 1'b1;
        last_grant_q <= grant_b;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          key_d   = mem_q[rptr_q];
          idx_d   = 3'd0;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        if (ep81_ready) begin
          idx_d = idx_q + 3'd1;   // wraps to 0 after byte 7
          if (idx_q == 3'd7) begin
            gap_d   = GAP_C;
            state_d = (GAP_CYCLES != 0) ? S_GAP1 : S_RELEASE;
          end
        end
      end
      S_GAP1: begin
        if (gap_q == 24'd1) begin
          idx_d   = 3'd0;
          state_d = S_RELEASE;
        end else begin
          gap_d = gap_q - 24'd1;
        end
      end
      S_RELEASE: begin
        if (ep81_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            gap_d   = GAP_C;
            state_d = (GAP_CYCLES != 0) ? S_GAP2 : S_IDLE;
          end
        end
      end
      S_GAP2: begin
        if (gap_q == 24'd1) state_d = S_IDLE;
        else                gap_d   = gap_q - 24'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Press report layout: modifiers, reserved, keycode, five empty key slots.
  assign ep81_valid = (state_q == S_PRESS) || (state_q == S_RELEASE);
  always_comb begin
    ep81_data = 8'h00;
    if (state_q == S_PRESS) begin
      if (idx_q == 3'd0)      ep81_data = key_q[15:8];
      else if (idx_q == 3'd2) ep81_data = key_q[7:0];
    end
  end

  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_hid_key_scheduler.sv
module tb_hid_key_scheduler;

  logic        clk = 1'b0;
  logic        usb_rstn = 1'b1;
  logic [15:0] a_key = '0, b_key = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        ep81_ready = 1'b0;

  logic        ar4, br4, v4, busy4;
  logic [7:0]  d4;
  logic [3:0]  cnt4;
  logic        ar0, br0, v0, busy0;
  logic [7:0]  d0;
  logic [3:0]  cnt0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q4[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  hid_key_scheduler #(.FIFO_AW(3), .GAP_CYCLES(4)) dut (
    .clk(clk), .usb_rstn(usb_rstn),
    .a_key(a_key), .a_valid(a_valid), .a_ready(ar4),
    .b_key(b_key), .b_valid(b_valid), .b_ready(br4),
    .ep81_data(d4), .ep81_valid(v4), .ep81_ready(ep81_ready),
    .fifo_count(cnt4), .busy(busy4)
  );

  hid_key_scheduler #(.FIFO_AW(3), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .usb_rstn(usb_rstn),
    .a_key(a_key), .a_valid(a_valid), .a_ready(ar0),
    .b_key(b_key), .b_valid(b_valid), .b_ready(br0),
    .ep81_data(d0), .ep81_valid(v0), .ep81_ready(ep81_ready),
    .fifo_count(cnt0), .busy(busy0)
  );

  always @(posedge clk) begin
    if (usb_rstn && v4 && ep81_ready) q4.push_back(d4);
    if (usb_rstn && v0 && ep81_ready) q0.push_back(d0);
  end

  task automatic do_reset();
    usb_rstn   = 1'b0;
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    a_key      = '0;
    b_key      = '0;
    ep81_ready = 1'b0;
    q4.delete();
    q0.delete();
    repeat (2) @(posedge clk);
    #1 usb_rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 usb_rstn = 1'b0;
    #1;
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", v4); end
    n_checks++; if (d4 !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", d4); end
    n_checks++; if (cnt4 !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy4); end
    n_checks++; if ({ar4, br4} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {ar4, br4}); end
    do_reset();
  endtask

  task automatic test_single();
    logic [7:0] press [8];
    logic       ev, eb;
    logic [7:0] ed;
    press = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    ep81_ready = 1'b1;
    a_key = 16'h0204;
    a_valid = 1'b1;
    #1;
    n_checks++; if (ar4 !== 1'b1) begin n_fail++; $display("FAIL single_a_ready got %b want 1", ar4); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    n_checks++; if (cnt4 !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", cnt4); end
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL single_latency_v got %b want 0", v4); end
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) begin
      ev = (k < 8) || (k >= 12 && k < 20);
      ed = (k < 8) ? press[k] : 8'h00;
      eb = (k < 24);
      n_checks++; if (v4 !== ev) begin n_fail++; $display("FAIL single_valid k=%0d got %b want %b", k, v4, ev); end
      if (ev) begin
        n_checks++; if (d4 !== ed) begin n_fail++; $display("FAIL single_data k=%0d got %h want %h", k, d4, ed); end
      end
      n_checks++; if (busy4 !== eb) begin n_fail++; $display("FAIL single_busy k=%0d got %b want %b", k, busy4, eb); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_tie();
    logic [7:0] ek;
    do_reset();
    ep81_ready = 1'b1;
    a_key = 16'h0004;
    b_key = 16'h0005;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (ar4 !== (i % 2 == 0)) begin n_fail++; $display("FAIL tie_a_ready i=%0d got %b", i, ar4); end
      n_checks++; if (br4 !== (i % 2 == 1)) begin n_fail++; $display("FAIL tie_b_ready i=%0d got %b", i, br4); end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    n_checks++; if (q4.size() != 96) begin n_fail++; $display("FAIL tie_bytes got %0d want 96", q4.size()); end
    for (int j = 0; j < 6; j++) begin
      ek = (j % 2 == 0) ? 8'h04 : 8'h05;
      n_checks++; if (q4[16*j+2] !== ek) begin n_fail++; $display("FAIL tie_order j=%0d got %h want %h", j, q4[16*j+2], ek); end
    end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL tie_busy got %b want 0", busy4); end
  endtask

  task automatic test_full();
    do_reset();
    ep81_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_key = {8'h01, 8'(16 + i)};
      a_valid = 1'b1;
      #1;
      n_checks++; if (ar4 !== (i < 9)) begin n_fail++; $display("FAIL full_a_ready i=%0d got %b want %b", i, ar4, (i < 9)); end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    n_checks++; if (cnt4 !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", cnt4); end
    ep81_ready = 1'b1;
    repeat (245) @(posedge clk);
    #1;
    n_checks++; if (q4.size() != 144) begin n_fail++; $display("FAIL full_bytes got %0d want 144", q4.size()); end
    for (int j = 0; j < 9; j++) begin
      n_checks++; if (q4[16*j] !== 8'h01) begin n_fail++; $display("FAIL full_mod j=%0d got %h want 01", j, q4[16*j]); end
      n_checks++; if (q4[16*j+2] !== 8'(16 + j)) begin n_fail++; $display("FAIL full_key j=%0d got %h want %h", j, q4[16*j+2], 8'(16 + j)); end
    end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL full_busy got %b want 0", busy4); end
  endtask

  task automatic test_backpressure();
    logic [15:0] keys [2];
    logic        pv, pr;
    logic [7:0]  pd, ed;
    int          idx;
    keys = '{16'h0204, 16'h0A1B};
    do_reset();
    ep81_ready = 1'b0;
    a_key = keys[0];
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_key = keys[1];
    @(posedge clk); #1;
    a_valid = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (pv && !pr) begin
        n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c=%0d got %b want 1", c, v4); end
        n_checks++; if (d4 !== pd) begin n_fail++; $display("FAIL bp_hold_data c=%0d got %h want %h", c, d4, pd); end
      end
      ep81_ready = 1'($urandom_range(0, 1));
      pv = v4; pr = ep81_ready; pd = d4;
      @(posedge clk); #1;
    end
    n_checks++; if (q4.size() != 32) begin n_fail++; $display("FAIL bp_bytes got %0d want 32", q4.size()); end
    for (int j = 0; j < 32; j++) begin
      idx = j % 16;
      ed = (idx == 0) ? keys[j/16][15:8] : (idx == 2) ? keys[j/16][7:0] : 8'h00;
      n_checks++; if (q4[j] !== ed) begin n_fail++; $display("FAIL bp_seq j=%0d got %h want %h", j, q4[j], ed); end
    end
  endtask

  task automatic test_gap0();
    logic [15:0] key;
    logic        ev;
    logic [7:0]  ed;
    int          j;
    do_reset();
    ep81_ready = 1'b1;
    a_key = 16'h0204;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_key = 16'h0305;
    @(posedge clk); #1;
    a_valid = 1'b0;
    for (int k = 0; k < 34; k++) begin
      ev  = (k != 16) && (k != 33);
      key = (k < 16) ? 16'h0204 : 16'h0305;
      j   = (k < 16) ? k : k - 17;
      ed  = (j == 0) ? key[15:8] : (j == 2) ? key[7:0] : 8'h00;
      n_checks++; if (v0 !== ev) begin n_fail++; $display("FAIL gap0_valid k=%0d got %b want %b", k, v0, ev); end
      if (ev) begin
        n_checks++; if (d0 !== ed) begin n_fail++; $display("FAIL gap0_data k=%0d got %h want %h", k, d0, ed); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    ep81_ready = 1'b1;
    a_key = 16'h0111;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_key = 16'h0122;
    @(posedge clk); #1;
    a_key = 16'h0133;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cnt4 !== 4'd2) begin n_fail++; $display("FAIL rmid_count_pre got %0d want 2", cnt4); end
    n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_pre got %b want 1", v4); end
    usb_rstn = 1'b0;
    #1;
    n_checks++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", v4); end
    n_checks++; if (cnt4 !== 4'd0) begin n_fail++; $display("FAIL rmid_count got %0d want 0", cnt4); end
    @(posedge clk); #1;
    usb_rstn = 1'b1;
    q4.delete();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (v4 === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_stale_valid got %0d cycles want 0", seen); end
    a_key = 16'h0708;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (q4.size() != 16) begin n_fail++; $display("FAIL rmid_bytes got %0d want 16", q4.size()); end
    n_checks++; if (q4[0] !== 8'h07) begin n_fail++; $display("FAIL rmid_mod got %h want 07", q4[0]); end
    n_checks++; if (q4[2] !== 8'h08) begin n_fail++; $display("FAIL rmid_key got %h want 08", q4[2]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_full();
    test_backpressure();
    test_gap0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
